// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit; owns the HI/LO registers and a busy countdown.
// Optional accumulate ops (madd/maddu/msub/msubu) are built only when MDU_MADD_EN is defined.
//
//   state  | meaning
//   S_IDLE | no long operation in flight; mult/div start, mthi/mtlo write directly
//   S_RUN  | result held in hi_pend/lo_pend, cnt counts down to the commit edge
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] E_RD1,
    input  logic [31:0] E_RD2,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] mdu_rdata,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi_pend, hi_pend_nxt;
    logic [31:0] lo_pend, lo_pend_nxt;
    logic [31:0] hi_nxt, lo_nxt;

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
    assign prod_u = {32'd0, E_RD1} * {32'd0, E_RD2};

    // Single unsigned divider on magnitudes; signs are restored afterwards so that
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
    logic        div_signed;
    logic        dvd_neg;
    logic        dvs_neg;
    logic        div_zero;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign div_signed = (mdu_op == OP_DIV);
    assign dvd_neg    = div_signed & E_RD1[31];
    assign dvs_neg    = div_signed & E_RD2[31];
    assign div_zero   = (E_RD2 == 32'd0);
    assign dvd_mag    = dvd_neg ? (~E_RD1 + 32'd1) : E_RD1;
    assign dvs_mag    = dvs_neg ? (~E_RD2 + 32'd1) : E_RD2;
    assign dvs_safe   = div_zero ? 32'd1 : dvs_mag;
    assign quo_mag    = dvd_mag / dvs_safe;
    assign rem_mag    = dvd_mag % dvs_safe;
    assign quo        = (dvd_neg ^ dvs_neg) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem        = dvd_neg ? (~rem_mag + 32'd1) : rem_mag;

`ifdef MDU_MADD_EN
    logic [63:0] acc_cur;
    logic [63:0] acc_prod;
    logic [63:0] acc_res;

    assign acc_cur  = {hi_q, lo_q};
    assign acc_prod = (mdu_op == OP_MADD || mdu_op == OP_MSUB) ? prod_s : prod_u;
    assign acc_res  = (mdu_op == OP_MSUB || mdu_op == OP_MSUBU) ? (acc_cur - acc_prod)
                                                                 : (acc_cur + acc_prod);
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_pend_nxt = hi_pend;
        lo_pend_nxt = lo_pend;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT: begin
                            {hi_pend_nxt, lo_pend_nxt} = prod_s;
                            cnt_nxt   = MULT_CNT;
                            state_nxt = S_RUN;
                        end
                        OP_MULTU: begin
                            {hi_pend_nxt, lo_pend_nxt} = prod_u;
                            cnt_nxt   = MULT_CNT;
                            state_nxt = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still burns the full latency but commits the old HI/LO.
                            if (div_zero) begin
                                hi_pend_nxt = hi_q;
                                lo_pend_nxt = lo_q;
                            end else begin
                                hi_pend_nxt = rem;
                                lo_pend_nxt = quo;
                            end
                            cnt_nxt   = DIV_CNT;
                            state_nxt = S_RUN;
                        end
                        OP_MTHI: hi_nxt = E_RD1;
                        OP_MTLO: lo_nxt = E_RD1;
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            {hi_pend_nxt, lo_pend_nxt} = acc_res;
                            cnt_nxt   = MULT_CNT;
                            state_nxt = S_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi_nxt    = hi_pend;
                    lo_nxt    = lo_pend;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_pend <= hi_pend_nxt;
            lo_pend <= lo_pend_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
        end
    end

    assign busy      = (state == S_RUN);
    assign mdu_rdata = rd_sel ? hi_q : lo_q;

endmodule
